// File: rtl/uart_rx_cfg_if.sv
// Serial receive interface: raw line in, per-frame word and error flags out.
// master = receiver side, slave = consumer/line-driver side.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 din;
  logic                 valid;
  logic [DATA_BITS-1:0] data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  din,
    output valid, data, parity_err, frame_err, busy
  );

  modport slave (
    output din,
    input  valid, data, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: mid-bit sampling, glitch-rejecting start,
// per-frame parity/framing flags committed with a one-cycle valid pulse.
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_cfg_if.master bus
);
  localparam int BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CW          = $clog2(BIT_CYCLES);
  localparam int BW          = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state, state_nx;
  logic                 sync1, din_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 bit_tick, commit, ferr_final;
  logic                 valid_q, perr_q, ferr_q;
  logic [DATA_BITS-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      din_s <= 1'b1;
    end else begin
      sync1 <= bus.din;
      din_s <= sync1;
    end
  end

  assign bit_tick = (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    commit     = 1'b0;
    ferr_final = ferr | ~din_s;
    case (state)
      S_IDLE:   if (!din_s) state_nx = S_START;
      S_START:  if (cnt == HALF_LAST) state_nx = din_s ? S_IDLE : S_DATA;
      S_DATA:   if (bit_tick && bit_idx == LAST_BIT)
                  state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_tick) state_nx = S_STOP;
      S_STOP:   if (bit_tick && stop_idx == STOP_LAST) begin
                  commit   = 1'b1;
                  state_nx = ferr_final ? S_BREAK : S_IDLE;
                end
      S_BREAK:  if (din_s) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Restart on every state entry and after each mid-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state_nx != state || bit_tick || state == S_IDLE || state == S_BREAK)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  // Right-shift fill lands the first received bit in data[0] after DATA_BITS samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= commit;
      if (commit) begin
        data_q <= shreg;
        perr_q <= perr;
        ferr_q <= ferr_final;
      end
      case (state)
        S_IDLE: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
        end
        S_DATA: if (bit_tick) begin
          shreg   <= {din_s, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + BW'(1);
        end
        S_PARITY: if (bit_tick) perr <= (^shreg) ^ din_s ^ (PARITY == 1);
        S_STOP: if (bit_tick) begin
          ferr     <= ferr_final;
          stop_idx <= ~stop_idx;
        end
        default: ;
      endcase
    end
  end

  assign bus.valid      = valid_q;
  assign bus.data       = data_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) checked against a
// frame-level reference model and a table of hand-computed vectors.
module tb_uart_rx_cfg;
  logic   clk = 1'b0;
  logic   rst_n;
  logic   line [3];
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_c ();

  uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  uart_rx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  assign if_a.din = line[0];
  assign if_b.din = line[1];
  assign if_c.din = line[2];

  logic       vld [3];
  logic [8:0] dat [3];
  logic       pe  [3];
  logic       fe  [3];
  logic       bsy [3];
  assign vld[0] = if_a.valid;  assign dat[0] = {1'b0, if_a.data};
  assign vld[1] = if_b.valid;  assign dat[1] = {2'b00, if_b.data};
  assign vld[2] = if_c.valid;  assign dat[2] = {1'b0, if_c.data};
  assign pe[0] = if_a.parity_err;  assign fe[0] = if_a.frame_err;  assign bsy[0] = if_a.busy;
  assign pe[1] = if_b.parity_err;  assign fe[1] = if_b.frame_err;  assign bsy[1] = if_b.busy;
  assign pe[2] = if_c.parity_err;  assign fe[2] = if_c.frame_err;  assign bsy[2] = if_c.busy;

  function automatic int db(input int d); return (d == 1) ? 7 : 8; endfunction
  function automatic int pm(input int d); return (d == 1) ? 2 : 0; endfunction
  function automatic int sb(input int d); return (d == 2) ? 2 : 1; endfunction

  typedef struct {
    int         dut;
    longint     cyc;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    int         dut;
    logic [8:0] word;
    logic       pbit;
    logic [1:0] stops;
    int         gap;
    logic [8:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  exp_t       exp_q [$];
  logic [8:0] last_data [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level reference: payload masked to width, parity by ones count, any low stop = framing error.
  function automatic exp_t model(input int d, input logic [8:0] w, input logic pbit, input logic [1:0] stops);
    exp_t m;
    int   ones;
    m.dut  = d;
    m.cyc  = 0;
    m.data = w & 9'((1 << db(d)) - 1);
    ones   = $countones(m.data) + int'(pbit);
    case (pm(d))
      1:       m.perr = (ones % 2) != 1;
      2:       m.perr = (ones % 2) != 0;
      default: m.perr = 1'b0;
    endcase
    m.ferr = !stops[0] || (sb(d) == 2 && !stops[1]);
    return m;
  endfunction

  // Entered and left at posedge+1; valid expected on the cycle after the last stop-bit sample.
  task automatic send_frame(input int d, input logic [8:0] w, input logic pbit, input logic [1:0] stops,
                            input logic [8:0] ed, input logic ep, input logic ef);
    logic [15:0] bits;
    int          n;
    exp_t        e;
    bits    = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < db(d); i++) bits[1 + i] = w[i];
    n = 1 + db(d);
    if (pm(d) != 0) begin bits[n] = pbit; n++; end
    for (int s = 0; s < sb(d); s++) begin bits[n] = stops[s]; n++; end
    e = '{d, cyc + 10 * n - 2, ed, ep, ef};
    exp_q.push_back(e);
    last_data[d] = ed;
    for (int j = 0; j < n; j++) begin
      line[d] = bits[j];
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int d, input int cycles);
    line[d] = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        if (vld[d]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (exp_q[k].dut == d && idx < 0) idx = k;
          if (idx < 0) begin
            check($sformatf("unexpected_valid[%0d]", d), 64'(vld[d]), 64'd0);
          end else begin
            check($sformatf("valid_cycle[%0d]", d), 64'(cyc), 64'(exp_q[idx].cyc));
            check($sformatf("data[%0d]", d), 64'(dat[d]), 64'(exp_q[idx].data));
            check($sformatf("parity_err[%0d]", d), 64'(pe[d]), 64'(exp_q[idx].perr));
            check($sformatf("frame_err[%0d]", d), 64'(fe[d]), 64'(exp_q[idx].ferr));
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [10];
    exp_t  m;
    logic  prev_ferr;
    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 20, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h03C, 1'b0, 2'b11,  0, 9'h03C, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h0C3, 1'b0, 2'b11, 20, 9'h0C3, 1'b0, 1'b0};
    vecs[3] = '{0, 9'h00F, 1'b0, 2'b00, 20, 9'h00F, 1'b0, 1'b1};
    vecs[4] = '{0, 9'h05A, 1'b0, 2'b11, 20, 9'h05A, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h041, 1'b1, 2'b11, 20, 9'h041, 1'b1, 1'b0};
    vecs[6] = '{1, 9'h041, 1'b0, 2'b11, 20, 9'h041, 1'b0, 1'b0};
    vecs[7] = '{1, 9'h07F, 1'b1, 2'b11, 20, 9'h07F, 1'b0, 1'b0};
    vecs[8] = '{2, 9'h012, 1'b0, 2'b11, 20, 9'h012, 1'b0, 1'b0};
    vecs[9] = '{2, 9'h0A5, 1'b0, 2'b10, 20, 9'h0A5, 1'b0, 1'b1};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin line[d] = 1'b1; last_data[d] = '0; end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_valid[%0d]", d), 64'(vld[d]), 64'd0);
      check($sformatf("rst_data[%0d]", d), 64'(dat[d]), 64'd0);
      check($sformatf("rst_perr[%0d]", d), 64'(pe[d]), 64'd0);
      check($sformatf("rst_ferr[%0d]", d), 64'(fe[d]), 64'd0);
      check($sformatf("rst_busy[%0d]", d), 64'(bsy[d]), 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int v = 0; v < 10; v++) begin
      send_frame(vecs[v].dut, vecs[v].word, vecs[v].pbit, vecs[v].stops,
                 vecs[v].e_data, vecs[v].e_perr, vecs[v].e_ferr);
      if (vecs[v].gap > 0) begin
        idle(vecs[v].dut, vecs[v].gap);
        check($sformatf("busy_after_vec%0d", v), 64'(bsy[vecs[v].dut]), 64'd0);
      end
    end

    // Short low pulse on the line must be rejected as a glitch.
    line[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    line[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_busy_high", 64'(bsy[0]), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("glitch_busy_low", 64'(bsy[0]), 64'd0);
    check("glitch_data_kept", 64'(dat[0]), 64'(last_data[0]));

    // Framing error followed by a held-low break line, then recovery.
    send_frame(2, 9'h055, 1'b0, 2'b01, 9'h055, 1'b0, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    check("break_busy_held", 64'(bsy[2]), 64'd1);
    idle(2, 10);
    check("break_released", 64'(bsy[2]), 64'd0);
    send_frame(2, 9'h012, 1'b0, 2'b11, 9'h012, 1'b0, 1'b0);
    idle(2, 20);

    // Reset during bit 4 of 0xFF aborts the frame.
    line[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    line[0] = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(vld[0]), 64'd0);
    check("midrst_data", 64'(dat[0]), 64'd0);
    check("midrst_busy", 64'(bsy[0]), 64'd0);
    check("midrst_ferr", 64'(fe[0]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) last_data[d] = '0;
    idle(0, 40);
    send_frame(0, 9'h081, 1'b0, 2'b11, 9'h081, 1'b0, 1'b0);
    idle(0, 20);

    for (int d = 0; d < 3; d++) begin
      prev_ferr = 1'b0;
      for (int f = 0; f < 8; f++) begin
        logic [8:0] w;
        logic       pbit;
        logic [1:0] stops;
        int         gap;
        w     = 9'($urandom_range(0, 511));
        pbit  = 1'($urandom_range(0, 1));
        stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        m     = model(d, w, pbit, stops);
        send_frame(d, w, pbit, stops, m.data, m.perr, m.ferr);
        gap = m.ferr ? int'($urandom_range(3, 12)) : int'($urandom_range(0, 12));
        if (gap > 0) idle(d, gap);
        prev_ferr = m.ferr;
      end
      idle(d, 20);
      if (!prev_ferr) check($sformatf("rand_busy_end[%0d]", d), 64'(bsy[d]), 64'd0);
    end

    repeat (30) @(posedge clk);
    #1;
    check("pending_frames", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the serial-link lab designs.
- Configurable data width, parity and stop-bit count.
- Validates the start bit at mid-bit and rejects glitches.
- Reports parity and framing errors alongside each received word.
- Sits between the board RX pin and the command/display logic; one word per frame, flagged by a single-cycle valid.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in bit/s; BIT_CYCLES = CLK_FREQ/BAUD_RATE, HALF_CYCLES = BIT_CYCLES/2 (integer division).
DATA_BITS, 8, payload bits per frame; legal 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked; legal 1 or 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  1  raw serial line, idle high, asynchronous to clk.
valid  output  1  one-cycle pulse: data/parity_err/frame_err updated this cycle.
data  output  DATA_BITS  last received word, LSB = first bit on line.
parity_err  output  1  parity mismatch in last frame (always 0 when PARITY=0).
frame_err  output  1  a stop bit sampled low in last frame.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, async): state IDLE, counters 0, sync flops 1, valid 0, data 0, parity_err 0, frame_err 0, busy 0.
- Input: din passes through a 2-flop synchroniser to din_s. All decisions use din_s; synchroniser latency is 2 cycles.
- Counter: cnt, width $clog2(BIT_CYCLES). It is cleared on every state entry.
- States and transitions:
  - IDLE: on din_s==0, go to START with cnt=0.
  - START: at cnt==HALF_CYCLES-1, sample din_s.
    - 1: glitch; return to IDLE with no valid.
    - 0: go to DATA with cnt=0, bit_idx=0.
    - All later samples occur at cnt==BIT_CYCLES-1, i.e. mid-bit.
  - DATA: at each sample, shift din_s into bit position bit_idx (LSB first). After bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
  - PARITY: at sample, set perr = (XOR of payload ^ din_s) != (PARITY==1 ? 1 : 0), i.e. odd parity requires total ones odd. Then go to STOP.
  - STOP: sample STOP_BITS stop bits. Any low sample sets ferr.
    - After the last stop sample with ferr==0: go to IDLE. No wait for the end of the stop bit, so back-to-back frames are received.
    - With ferr==1: go to BREAK_WAIT.
  - BREAK_WAIT: remain until din_s==1, then go to IDLE. This prevents a held-low (break) line from retriggering.
- Output commit: on the cycle after the last stop sample, valid=1 and data, parity_err, frame_err load the frame results together. valid is low in every other cycle. Outputs hold until the next commit.
- Flags are per-frame and overwritten at every commit. A frame with errors still pulses valid and updates data.
- Latency: valid rises 2 (sync) + 1 cycles after the mid-point of the final stop bit on din.
- A glitch-rejected start never touches the outputs.
- Reset mid-frame aborts immediately: no valid, outputs return to reset values.
- DATA_BITS=9: data[8] is the 9th bit received.

Test Plan:
(Bench: CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BIT_CYCLES=10, HALF=5.)
- 8N1, send 0xA5 then idle -> exactly one valid pulse, data=0xA5, parity_err=0, frame_err=0, busy low after commit.
- Two back-to-back frames 0x3C, 0xC3 with no idle gap -> two valid pulses 100 cycles apart, data 0x3C then 0xC3.
- din low for 3 cycles only, then high -> no valid, busy returns low within 8 cycles, data unchanged.
- PARITY=2 (even), DATA_BITS=7, send 0x41 with parity bit 1 -> data=0x41, parity_err=1. Same frame with parity bit 0 -> parity_err=0.
- STOP_BITS=2, send 0x55 with second stop bit 0 -> valid, data=0x55, frame_err=1. din held low 50 more cycles -> no further valid; next clean frame 0x12 -> data=0x12, frame_err=0.
- Assert rst_n low during bit 4 of 0xFF -> outputs 0 immediately, no valid. Release, send 0x81 -> data=0x81.
